// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and queued load results
// into one registered register-file write port.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     AluValid,
  input  logic [4:0]               AluRD,
  input  logic [31:0]              AluData,
  input  logic                     MemValid,
  input  logic [4:0]               MemRD,
  input  logic [31:0]              MemData,
  output logic                     MemReady,
  output logic [4:0]               RD,
  output logic [31:0]              WData,
  output logic                     RegWr,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [31:0]              Pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          q_live [DEPTH];
  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic enq;
  logic deq;
  logic kill;

  assign MemReady = cnt < CW'(DEPTH);
  assign Count    = cnt;
  assign enq      = MemValid && MemReady;
  assign deq      = !AluValid && (cnt != '0);
  assign kill     = AluValid && (AluRD != 5'd0);

  always_comb begin
    Pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rptr;
      if (({1'b0, off} < cnt) && q_live[i])
        Pending[q_rd[i]] = 1'b1;
    end
    Pending[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWr <= 1'b0;
      RD    <= '0;
      WData <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++)
        q_live[i] <= 1'b0;
    end else begin
      // younger ALU write kills every older queued write to its rd
      for (int i = 0; i < DEPTH; i++)
        if (kill && q_rd[i] == AluRD)
          q_live[i] <= 1'b0;
      if (enq) begin
        q_live[wptr] <= !(kill && MemRD == AluRD);
        q_rd[wptr]   <= MemRD;
        q_data[wptr] <= MemData;
        wptr         <= wptr + 1'b1;
      end
      if (AluValid) begin
        RegWr <= AluRD != 5'd0;
        RD    <= AluRD;
        WData <= AluData;
      end else if (deq) begin
        RegWr <= q_live[rptr] && (q_rd[rptr] != 5'd0);
        RD    <= q_rd[rptr];
        WData <= q_data[rptr];
        rptr  <= rptr + 1'b1;
      end else begin
        RegWr <= 1'b0;
      end
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based model of the write-back rules.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AluValid;
  logic [4:0]  AluRD;
  logic [31:0] AluData;
  logic        MemValid;
  logic [4:0]  MemRD;
  logic [31:0] MemData;
  logic        MemReady;
  logic [4:0]  RD;
  logic [31:0] WData;
  logic        RegWr;
  logic [2:0]  Count;
  logic [31:0] Pending;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluRD(AluRD), .AluData(AluData),
    .MemValid(MemValid), .MemRD(MemRD), .MemData(MemData),
    .MemReady(MemReady), .RD(RD), .WData(WData), .RegWr(RegWr),
    .Count(Count), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          live;
    bit [4:0]    rd;
    bit [31:0]   data;
  } ent_t;

  ent_t      mq[$];
  bit        m_wr;
  bit [4:0]  m_rd;
  bit [31:0] m_wd;
  bit        started;
  bit [31:0] dut_rf [32];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_pending();
    bit [31:0] p = '0;
    foreach (mq[i])
      if (mq[i].live && mq[i].rd != 0) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic step(input bit rst, input bit av, input bit [4:0] ard,
                      input bit [31:0] adat, input bit mv,
                      input bit [4:0] mrd, input bit [31:0] mdat);
    bit enq;
    ent_t e;
    Reset = rst; AluValid = av; AluRD = ard; AluData = adat;
    MemValid = mv; MemRD = mrd; MemData = mdat;
    #1;
    if (started) begin
      check("memready", 32'(MemReady), 32'(mq.size() < DEPTH));
      check("count", 32'(Count), 32'(mq.size()));
      check("pending", Pending, m_pending());
    end
    if (rst) begin
      mq.delete();
      m_wr = 0; m_rd = 0; m_wd = 0;
    end else begin
      enq = mv && (mq.size() < DEPTH);
      if (av) begin
        m_wr = ard != 0; m_rd = ard; m_wd = adat;
        if (ard != 0)
          foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 0;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wr = e.live && e.rd != 0; m_rd = e.rd; m_wd = e.data;
      end else begin
        m_wr = 0;
      end
      if (enq) begin
        e.live = !(av && ard != 0 && mrd == ard);
        e.rd = mrd; e.data = mdat;
        mq.push_back(e);
      end
    end
    @(posedge Clk);
    #1;
    started = 1;
    check("regwr", 32'(RegWr), 32'(m_wr));
    check("rd", 32'(RD), 32'(m_rd));
    check("wdata", WData, m_wd);
    if (RegWr === 1'b1) dut_rf[RD] = WData;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    started = 0;
    foreach (dut_rf[i]) dut_rf[i] = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_count", 32'(Count), 32'd0);
    check("reset_ready", 32'(MemReady), 32'd1);

    step(0, 1, 5, 32'h1234, 0, 0, 0);
    check("alu_r5", {RegWr, 26'd0, RD}, {1'b1, 26'd0, 5'd5});
    idle(1);
    check("alu_one_cycle", 32'(RegWr), 32'd0);

    // keep the ALU busy on r20 so the load queue fills up
    for (int i = 1; i <= 4; i++)
      step(0, 1, 20, 32'h2000 + i, 1, 5'(i), 32'hA0 + i);
    step(0, 1, 20, 32'h2005, 1, 5, 32'hA5);
    check("full_ready", 32'(MemReady), 32'd0);
    idle(1);
    check("drain_r1", WData, 32'hA1);
    idle(5);
    check("fill_pending", Pending, 32'd0);

    step(0, 1, 21, 32'h1, 1, 7, 32'hDEAD);
    step(0, 1, 7, 32'hBEEF, 0, 0, 0);
    idle(3);
    check("r7_final", dut_rf[7], 32'hBEEF);

    step(0, 1, 9, 32'h9999, 1, 9, 32'h5555);
    check("pending9", 32'(Pending[9]), 32'd0);
    idle(3);
    check("r9_final", dut_rf[9], 32'h9999);

    step(0, 1, 0, 32'h1111, 1, 0, 32'h2222);
    idle(3);
    check("r0_untouched", dut_rf[0], 32'd0);

    for (int i = 0; i < 3; i++)
      step(0, 1, 22, 32'h3000 + i, 1, 5'(10 + i), 32'hC0 + i);
    step(1, 1, 23, 32'h4444, 0, 0, 0);
    check("rst_count", 32'(Count), 32'd0);
    idle(4);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
    idle(6);
    check("end_count", 32'(Count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
